// File: rtl/console_tx.sv
// console_tx: memory-mapped console output port for a soft CPU.
//   Writes to 24'hFFFFFE queue i_dout[7:0] in a byte FIFO that an 8N1 UART
//   transmitter drains. A write to 24'hFFFFFF requests a halt. o_halt rises
//   once that request is pending, the FIFO is empty and the transmitter is idle.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_clk_en         clock enable; all state holds when low (reset still applies)
//   i_daddr, i_dout  CPU data address / write data, qualified by i_wr
//   o_txd            serial output, idle high
//   o_halt           sticky halt-and-drained flag
//   o_fifo_level     FIFO occupancy
//   o_drop_cnt       saturating count of bytes lost to a full FIFO
module console_tx #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 16,
   localparam int unsigned AW = $clog2(FIFO_DEPTH),
   localparam int unsigned LW = AW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clk_en,
   input  logic [23:0]   i_daddr,
   input  logic [31:0]   i_dout,
   input  logic          i_wr,
   output logic          o_txd,
   output logic          o_halt,
   output logic [LW-1:0] o_fifo_level,
   output logic [7:0]    o_drop_cnt
);

   localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [15:0]     baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      data_q, data_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   count_q, count_d;
   logic [7:0]      drop_q, drop_d;
   logic            halt_req_q, halt_req_d;
   logic            halt_q, halt_d;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic stdout_wr, halt_wr, push_req, push, pop, full, drop, baud_done, halt_cond;

   assign stdout_wr = i_wr && (i_daddr == 24'hFFFFFE);
   assign halt_wr   = i_wr && (i_daddr == 24'hFFFFFF);
   assign full      = (count_q == LEVEL_FULL);
   // Console writes after a halt request are silently discarded.
   assign push_req  = i_clk_en && stdout_wr && !halt_req_q;
   assign pop       = i_clk_en && (state_q == StIdle) && (count_q != '0);
   // A full FIFO still accepts a byte when a slot frees up in the same cycle.
   assign push      = push_req && (!full || pop);
   assign drop      = push_req && full && !pop;
   assign baud_done = (baud_q == BAUD_LAST);
   assign halt_cond = halt_req_q && (count_q == '0) && (state_q == StIdle);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      drop_d     = drop_q;
      halt_req_d = halt_req_q;
      halt_d     = halt_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + LW'(1);
      else if (pop && !push) count_d = count_q - LW'(1);
      if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
      if (i_clk_en && halt_wr)   halt_req_d = 1'b1;
      if (i_clk_en && halt_cond) halt_d = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      data_d  = data_q;
      if (i_clk_en) begin
         unique case (state_q)
            StIdle: begin
               if (count_q != '0) begin
                  data_d  = mem_q[rd_ptr_q];
                  baud_d  = '0;
                  state_d = StStart;
               end
            end
            StStart: begin
               if (baud_done) begin
                  baud_d  = '0;
                  bit_d   = '0;
                  state_d = StData;
               end else begin
                  baud_d = baud_q + 16'd1;
               end
            end
            StData: begin
               if (baud_done) begin
                  baud_d = '0;
                  if (bit_q == 3'd7) state_d = StStop;
                  else               bit_d   = bit_q + 3'd1;
               end else begin
                  baud_d = baud_q + 16'd1;
               end
            end
            StStop: begin
               if (baud_done) begin
                  baud_d  = '0;
                  state_d = StIdle;
               end else begin
                  baud_d = baud_q + 16'd1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      o_txd = 1'b1;
      unique case (state_q)
         StStart: o_txd = 1'b0;
         StData:  o_txd = data_q[bit_q];
         default: o_txd = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= StIdle;
         baud_q     <= '0;
         bit_q      <= '0;
         data_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_q     <= '0;
         halt_req_q <= 1'b0;
         halt_q     <= 1'b0;
      end else if (i_clk_en) begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         data_q     <= data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_q     <= drop_d;
         halt_req_q <= halt_req_d;
         halt_q     <= halt_d;
      end
   end

   // Storage needs no reset: pointers and count define which entries are valid.
   always_ff @(posedge i_clk) begin
      if (!i_rst && push) mem_q[wr_ptr_q] <= i_dout[7:0];
   end

   // Combinational term lets o_halt rise in the very cycle the condition first holds.
   assign o_halt       = halt_q | halt_cond;
   assign o_fifo_level = count_q;
   assign o_drop_cnt   = drop_q;

endmodule

// File: tb/tb_console_tx.sv
// Directed bench for console_tx with CLKS_PER_BIT=4, FIFO_DEPTH=16.
module tb_console_tx;

   localparam int unsigned Cpb   = 4;
   localparam int unsigned Depth = 16;
   localparam int          Tmo   = 600;

   logic        i_clk = 1'b0;
   logic        i_rst, i_clk_en, i_wr;
   logic [23:0] i_daddr;
   logic [31:0] i_dout;
   logic        o_txd, o_halt;
   logic [4:0]  o_fifo_level;
   logic [7:0]  o_drop_cnt;

   logic en_main = 1'b1;
   logic en_tog  = 1'b1;
   bit   tog_on  = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   assign i_clk_en = tog_on ? en_tog : en_main;

   console_tx #(.CLKS_PER_BIT(Cpb), .FIFO_DEPTH(Depth)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clk_en     (i_clk_en),
      .i_daddr      (i_daddr),
      .i_dout       (i_dout),
      .i_wr         (i_wr),
      .o_txd        (o_txd),
      .o_halt       (o_halt),
      .o_fifo_level (o_fifo_level),
      .o_drop_cnt   (o_drop_cnt)
   );

   always #5 i_clk = ~i_clk;
   always @(negedge i_clk) if (tog_on) en_tog = ~en_tog;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // All tasks are entered on a falling edge and return on one.
   task automatic bus_write(input logic [23:0] a, input logic [31:0] d);
      i_wr = 1'b1; i_daddr = a; i_dout = d;
      @(negedge i_clk);
      i_wr = 1'b0; i_daddr = '0; i_dout = '0;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   // Waits for a start bit, then samples every clock of a 10-bit frame of bclk
   // clocks per bit. bad counts samples disagreeing with the first sample of
   // their bit plus framing errors; -1 flags a timeout. gap = idle samples seen.
   task automatic recv_frame(input int bclk, output logic [7:0] data, output int bad,
                             output int gap);
      logic [9:0] bits;
      bad = 0; gap = 0; data = '0; bits = '0;
      @(negedge i_clk);
      while (o_txd !== 1'b0 && gap < Tmo) begin
         @(negedge i_clk);
         gap++;
      end
      if (gap >= Tmo) begin
         bad = -1;
         return;
      end
      for (int i = 0; i < 10 * bclk; i++) begin
         if (i > 0) @(negedge i_clk);
         if (i % bclk == 0) bits[i / bclk] = o_txd;
         else if (o_txd !== bits[i / bclk]) bad++;
      end
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) bad++;
      data = bits[8:1];
   endtask

   initial begin
      logic [7:0] d;
      int bad, gap, viol;
      i_rst = 1'b1; i_wr = 1'b0; i_daddr = '0; i_dout = '0;
      @(negedge i_clk);
      do_reset();

      // Reset state
      check("rst_txd",   o_txd, 1);
      check("rst_halt",  o_halt, 0);
      check("rst_level", o_fifo_level, 0);
      check("rst_drop",  o_drop_cnt, 0);

      // Non-console address is ignored
      bus_write(24'h123456, 32'h99);
      check("other_addr_level", o_fifo_level, 0);

      // Single byte 0x41, upper data bits ignored
      bus_write(24'hFFFFFE, 32'hABCDEF41);
      check("single_level_after_push", o_fifo_level, 1);
      recv_frame(Cpb, d, bad, gap);
      check("single_data", d, 8'h41);
      check("single_shape", bad, 0);
      check("single_start_latency", gap, 0);
      @(negedge i_clk);
      check("single_idle_after", o_txd, 1);
      check("single_level_end", o_fifo_level, 0);

      // 20 writes during the first frame: 17 accepted, 3 dropped
      do_reset();
      fork
         begin
            for (int i = 0; i < 20; i++) bus_write(24'hFFFFFE, 32'(i));
            check("burst_level_full", o_fifo_level, Depth);
         end
         begin
            for (int k = 0; k < 17; k++) begin
               recv_frame(Cpb, d, bad, gap);
               check($sformatf("burst_data_%0d", k), d, k);
               check($sformatf("burst_shape_%0d", k), bad, 0);
               if (k > 0) check($sformatf("burst_gap_%0d", k), gap, 1);
            end
         end
      join
      check("burst_drop", o_drop_cnt, 3);
      repeat (3) @(negedge i_clk);
      check("burst_level_end", o_fifo_level, 0);
      check("burst_txd_idle", o_txd, 1);

      // Drop counter saturates
      do_reset();
      for (int i = 0; i < 320; i++) bus_write(24'hFFFFFE, 32'h5A);
      check("drop_saturate", o_drop_cnt, 255);

      // Halt sequence
      do_reset();
      fork
         begin
            bus_write(24'hFFFFFE, 32'h55);
            bus_write(24'hFFFFFE, 32'hAA);
            bus_write(24'hFFFFFF, 32'h0);
            bus_write(24'hFFFFFE, 32'h77);
         end
         begin
            recv_frame(Cpb, d, bad, gap);
            check("halt_frame1", d, 8'h55);
            check("halt_frame1_shape", bad, 0);
            check("halt_low_mid", o_halt, 0);
            recv_frame(Cpb, d, bad, gap);
            check("halt_frame2", d, 8'hAA);
            check("halt_frame2_shape", bad, 0);
            check("halt_low_in_stop", o_halt, 0);
         end
      join
      @(negedge i_clk);
      check("halt_rise", o_halt, 1);
      check("halt_level", o_fifo_level, 0);
      check("halt_no_drop", o_drop_cnt, 0);
      viol = 0;
      repeat (100) begin
         @(negedge i_clk);
         if (o_txd !== 1'b1 || o_halt !== 1'b1) viol++;
      end
      check("halt_sticky_quiet", viol, 0);

      // Clock enable toggling: every bit lasts 2*Cpb clocks
      do_reset();
      bus_write(24'hFFFFFE, 32'h41);
      en_tog = 1'b1;
      tog_on = 1'b1;
      recv_frame(2 * Cpb, d, bad, gap);
      tog_on = 1'b0;
      en_main = 1'b1;
      check("clken_data", d, 8'h41);
      check("clken_shape", bad, 0);

      // Reset mid-DATA with 3 bytes queued, clock enable low during reset
      do_reset();
      for (int i = 0; i < 4; i++) bus_write(24'hFFFFFE, 32'hF0 + 32'(i));
      repeat (12) @(negedge i_clk);
      check("abort_level_before", o_fifo_level, 3);
      i_rst = 1'b1;
      en_main = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b0;
      en_main = 1'b1;
      check("abort_txd", o_txd, 1);
      check("abort_level", o_fifo_level, 0);
      viol = 0;
      repeat (200) begin
         @(negedge i_clk);
         if (o_txd !== 1'b1) viol++;
      end
      check("abort_no_frame", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/console_tx.md
CONSOLE_TX -- requirements
Module: console_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868: enabled clock cycles per UART bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16: byte FIFO depth; power of two, 2..256.
REQ-003 Clocking and reset are fixed: one clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  system clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_clk_en  input  1  clock enable; when 0, all state holds.
REQ-007 i_daddr  input  24  CPU data address.
REQ-008 i_dout  input  32  CPU write data.
REQ-009 i_wr  input  1  CPU write strobe.
REQ-010 o_txd  output  1  UART serial output, 8N1, idle high.
REQ-011 o_halt  output  1  sticky: halt requested and all console output drained.
REQ-012 o_fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 o_drop_cnt  output  8  count of bytes dropped because the FIFO was full; saturates at 255.

Function
REQ-014 State SHALL advance only on cycles with i_clk_en=1 and i_rst=0.
REQ-015 A STDOUT write is i_wr=1 with i_daddr=24'hFFFFFE; a HALT write is i_wr=1 with i_daddr=24'hFFFFFF; all other addresses are ignored.
REQ-016 A STDOUT write SHALL push i_dout[7:0] into the FIFO; i_dout[31:8] are ignored.
REQ-017 A push with FIFO full and no pop in the same cycle SHALL be dropped and SHALL increment o_drop_cnt (saturating at 255).
REQ-018 A push with FIFO full and a pop in the same cycle SHALL be accepted; the level stays at FIFO_DEPTH.
REQ-019 The FIFO SHALL be first-in first-out; pointers SHALL wrap modulo FIFO_DEPTH without loss or duplication.
REQ-020 The TX FSM SHALL have the states IDLE, START, DATA and STOP, with a bit counter of 3 bits and a baud counter of 16 bits.
REQ-021 IDLE: o_txd=1; when the FIFO is non-empty, the FSM SHALL pop one byte, latch it and go to START; o_txd=0 from the next cycle.
REQ-022 START: the FSM SHALL hold o_txd=0 for CLKS_PER_BIT enabled cycles, then go to DATA.
REQ-023 DATA: the FSM SHALL send bits 0..7 (LSB first), each for CLKS_PER_BIT enabled cycles, then go to STOP.
REQ-024 STOP: the FSM SHALL hold o_txd=1 for CLKS_PER_BIT enabled cycles, then go to IDLE.
REQ-025 A frame SHALL last 10*CLKS_PER_BIT enabled cycles; back-to-back frames SHALL have at most 1 idle cycle between the stop bit and the next start bit.
REQ-026 A HALT write SHALL set an internal halt_req flag (sticky).
REQ-027 o_halt SHALL assert on the first cycle in which halt_req=1, the FIFO is empty and the FSM is in IDLE.
REQ-028 o_halt SHALL remain asserted until reset.
REQ-029 STDOUT writes with halt_req=1 SHALL be ignored and not counted in o_drop_cnt.
REQ-030 If HALT and STDOUT writes fall in the same cycle, the address decides which one applies; only one can match.
REQ-031 o_fifo_level SHALL equal the number of pushes minus the number of pops, updated in the cycle after the push or pop.

Reset
REQ-032 i_rst=1 SHALL take effect regardless of i_clk_en.
REQ-033 On reset: o_txd=1, o_halt=0, o_fifo_level=0, o_drop_cnt=0, halt_req=0, FSM=IDLE, FIFO pointers=0, counters=0.
REQ-034 Reset during a frame SHALL abort the frame: o_txd=1 from the cycle after reset is sampled, and the FIFO contents SHALL be discarded.

Verification
REQ-035 CLKS_PER_BIT=4, write 0x41 to FFFFFE -> o_txd low 4 cycles, then 1,0,0,0,0,0,1,0 for 4 cycles each, then high 4 cycles; o_fifo_level returns to 0.
REQ-036 FIFO_DEPTH=16, 20 consecutive STDOUT writes (0x00..0x13) during the first frame -> o_drop_cnt=3, and bytes 0x00..0x10 are transmitted in order.
REQ-037 300 dropped writes -> o_drop_cnt saturates at 255.
REQ-038 Write 0x55, 0x AA, then HALT, then 0x77 -> 0x55 and 0xAA are transmitted, 0x77 is never transmitted; o_halt rises at the first IDLE after the 0xAA stop bit and stays high.
REQ-039 i_clk_en toggling 1/0 every cycle with CLKS_PER_BIT=4 -> every bit lasts 8 clocks; output is identical to the always-enabled case.
REQ-040 Assert i_rst for 1 cycle mid-DATA with 3 bytes queued -> o_txd=1, o_fifo_level=0 next cycle; no further frame is sent.
